// File: rtl/tcam_lut_hitcnt_sm.sv
// Register-based ternary CAM with LUT, lowest-index priority, multi-match flag,
// per-entry saturating hit counters and lookup/register-access arbitration.
module tcam_lut_hitcnt_sm #(
    parameter int CMP_WIDTH      = 32,
    parameter int DATA_WIDTH     = 3,
    parameter int LUT_DEPTH      = 16,
    parameter int LUT_DEPTH_BITS = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1,
    parameter int COUNT_WIDTH    = 16,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA   = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      ready,
    input  logic                      lookup_req,
    input  logic [CMP_WIDTH-1:0]      lookup_cmp_data,
    input  logic [CMP_WIDTH-1:0]      lookup_cmp_dmask,
    output logic                      lookup_ack,
    output logic                      lookup_hit,
    output logic                      lookup_multi,
    output logic [LUT_DEPTH_BITS-1:0] lookup_addr,
    output logic [DATA_WIDTH-1:0]     lookup_data,
    input  logic                      rd_req,
    input  logic [LUT_DEPTH_BITS-1:0] rd_addr,
    input  logic                      rd_clr_count,
    output logic                      rd_ack,
    output logic                      rd_valid,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [CMP_WIDTH-1:0]      rd_cmp_data,
    output logic [CMP_WIDTH-1:0]      rd_cmp_dmask,
    output logic [COUNT_WIDTH-1:0]    rd_hit_count,
    input  logic                      wr_req,
    input  logic [LUT_DEPTH_BITS-1:0] wr_addr,
    input  logic                      wr_valid,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [CMP_WIDTH-1:0]      wr_cmp_data,
    input  logic [CMP_WIDTH-1:0]      wr_cmp_dmask,
    output logic                      wr_ack
);

    localparam logic [LUT_DEPTH_BITS-1:0] LAST_IDX  = LUT_DEPTH_BITS'(LUT_DEPTH - 1);
    localparam logic [LUT_DEPTH_BITS:0]   DEPTH_EXT = (LUT_DEPTH_BITS + 1)'(LUT_DEPTH);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                    state_q, state_d;
    logic [LUT_DEPTH_BITS-1:0] init_idx_q, init_idx_d;
    logic                      sweep_en;

    logic                      valid_q [LUT_DEPTH];
    logic [DATA_WIDTH-1:0]     data_q  [LUT_DEPTH];
    logic [CMP_WIDTH-1:0]      cmp_q   [LUT_DEPTH];
    logic [CMP_WIDTH-1:0]      mask_q  [LUT_DEPTH];
    logic [COUNT_WIDTH-1:0]    cnt_q   [LUT_DEPTH];

    logic [LUT_DEPTH-1:0]      match_d, s1_match_q;
    logic                      s1_vld_q, s2_vld_q, s2_hit_q, s2_multi_q;
    logic [LUT_DEPTH_BITS-1:0] s2_addr_q, enc_addr;
    logic                      enc_hit, enc_multi;

    logic                      lk_ack_q, lk_hit_q, lk_multi_q;
    logic [LUT_DEPTH_BITS-1:0] lk_addr_q;
    logic [DATA_WIDTH-1:0]     lk_data_q;
    logic                      rd_ack_q, rd_valid_q, wr_ack_q;
    logic [DATA_WIDTH-1:0]     rd_data_q;
    logic [CMP_WIDTH-1:0]      rd_cmp_q, rd_mask_q;
    logic [COUNT_WIDTH-1:0]    rd_cnt_q;

    logic lookup_go, wr_grant, rd_grant, wr_in_range, rd_in_range, inc_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == ST_INIT) begin
            init_idx_d = init_idx_q + LUT_DEPTH_BITS'(1);
            if (init_idx_q == LAST_IDX) begin
                state_d    = ST_READY;
                init_idx_d = '0;
            end
        end
    end

    always_comb begin
        ready    = (state_q == ST_READY);
        sweep_en = (state_q == ST_INIT) && !reset;
    end

    // Requests are levels; each granted cycle produces one ack pulse a cycle later,
    // so a req still high in its ack cycle is taken as a fresh request.
    assign lookup_go   = ready && !reset && lookup_req;
    assign wr_grant    = ready && !reset && wr_req && !lookup_req;
    assign rd_grant    = ready && !reset && rd_req && !wr_grant;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
    assign inc_en      = s2_vld_q && s2_hit_q && !reset;

    always_comb begin
        for (int e = 0; e < LUT_DEPTH; e++) begin
            match_d[e] = valid_q[e] &&
                (((lookup_cmp_data ^ cmp_q[e]) & ~(mask_q[e] | lookup_cmp_dmask)) == '0);
        end
    end

    // Descending scan leaves the lowest matching index as the winner.
    always_comb begin
        enc_addr = '0;
        for (int e = LUT_DEPTH - 1; e >= 0; e--) begin
            if (s1_match_q[e]) enc_addr = LUT_DEPTH_BITS'(e);
        end
        enc_hit   = |s1_match_q;
        enc_multi = |(s1_match_q & (s1_match_q - LUT_DEPTH'(1)));
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < LUT_DEPTH; e++) begin
            if (sweep_en && init_idx_q == LUT_DEPTH_BITS'(e)) begin
                valid_q[e] <= 1'b0;
                data_q[e]  <= RESET_DATA;
                cmp_q[e]   <= '0;
                mask_q[e]  <= '0;
                cnt_q[e]   <= '0;
            end else if (wr_grant && wr_in_range && wr_addr == LUT_DEPTH_BITS'(e)) begin
                valid_q[e] <= wr_valid;
                data_q[e]  <= wr_data;
                cmp_q[e]   <= wr_cmp_data;
                mask_q[e]  <= wr_cmp_dmask;
                cnt_q[e]   <= '0;
            end else if (rd_grant && rd_in_range && rd_clr_count && rd_addr == LUT_DEPTH_BITS'(e)) begin
                cnt_q[e] <= (inc_en && s2_addr_q == LUT_DEPTH_BITS'(e)) ? COUNT_WIDTH'(1) : '0;
            end else if (inc_en && s2_addr_q == LUT_DEPTH_BITS'(e) && cnt_q[e] != '1) begin
                cnt_q[e] <= cnt_q[e] + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            s1_match_q <= '0;
            s2_vld_q   <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_multi_q <= 1'b0;
            s2_addr_q  <= '0;
            lk_ack_q   <= 1'b0;
            lk_hit_q   <= 1'b0;
            lk_multi_q <= 1'b0;
            lk_addr_q  <= '0;
            lk_data_q  <= DEFAULT_DATA;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_cmp_q   <= '0;
            rd_mask_q  <= '0;
            rd_cnt_q   <= '0;
        end else begin
            s1_vld_q   <= lookup_go;
            s1_match_q <= match_d;
            s2_vld_q   <= s1_vld_q;
            s2_hit_q   <= enc_hit;
            s2_multi_q <= enc_multi;
            s2_addr_q  <= enc_addr;
            lk_ack_q   <= s2_vld_q;
            lk_hit_q   <= s2_vld_q && s2_hit_q;
            lk_multi_q <= s2_vld_q && s2_multi_q;
            lk_addr_q  <= (s2_vld_q && s2_hit_q) ? s2_addr_q : '0;
            lk_data_q  <= (s2_vld_q && s2_hit_q) ? data_q[s2_addr_q] : DEFAULT_DATA;
            wr_ack_q   <= wr_grant;
            rd_ack_q   <= rd_grant;
            if (rd_grant) begin
                rd_valid_q <= rd_in_range ? valid_q[rd_addr] : 1'b0;
                rd_data_q  <= rd_in_range ? data_q[rd_addr]  : '0;
                rd_cmp_q   <= rd_in_range ? cmp_q[rd_addr]   : '0;
                rd_mask_q  <= rd_in_range ? mask_q[rd_addr]  : '0;
                rd_cnt_q   <= rd_in_range ? cnt_q[rd_addr]   : '0;
            end
        end
    end

    assign lookup_ack   = lk_ack_q;
    assign lookup_hit   = lk_hit_q;
    assign lookup_multi = lk_multi_q;
    assign lookup_addr  = lk_addr_q;
    assign lookup_data  = lk_data_q;
    assign rd_ack       = rd_ack_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_cmp_data  = rd_cmp_q;
    assign rd_cmp_dmask = rd_mask_q;
    assign rd_hit_count = rd_cnt_q;
    assign wr_ack       = wr_ack_q;

endmodule

// File: tb/tb_tcam_lut_hitcnt_sm.sv
// Directed bench for tcam_lut_hitcnt_sm: sweep, lookups, priority, counters,
// arbitration and mid-stream reset, with hand-computed expectations.
module tb_tcam_lut_hitcnt_sm;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        lookup_req;
    logic [31:0] lookup_cmp_data, lookup_cmp_dmask;
    logic        lookup_ack, lookup_hit, lookup_multi;
    logic [3:0]  lookup_addr;
    logic [2:0]  lookup_data;
    logic        rd_req, rd_clr_count, rd_ack, rd_valid;
    logic [3:0]  rd_addr;
    logic [2:0]  rd_data;
    logic [31:0] rd_cmp_data, rd_cmp_dmask;
    logic [2:0]  rd_hit_count;
    logic        wr_req, wr_valid, wr_ack;
    logic [3:0]  wr_addr;
    logic [2:0]  wr_data;
    logic [31:0] wr_cmp_data, wr_cmp_dmask;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] DEF_D = 3'd6;
    localparam logic [2:0] RST_D = 3'd1;

    tcam_lut_hitcnt_sm #(
        .CMP_WIDTH(32), .DATA_WIDTH(3), .LUT_DEPTH(16), .COUNT_WIDTH(3),
        .DEFAULT_DATA(DEF_D), .RESET_DATA(RST_D)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .lookup_req(lookup_req), .lookup_cmp_data(lookup_cmp_data),
        .lookup_cmp_dmask(lookup_cmp_dmask), .lookup_ack(lookup_ack),
        .lookup_hit(lookup_hit), .lookup_multi(lookup_multi),
        .lookup_addr(lookup_addr), .lookup_data(lookup_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_clr_count(rd_clr_count),
        .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_cmp_data(rd_cmp_data), .rd_cmp_dmask(rd_cmp_dmask),
        .rd_hit_count(rd_hit_count),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_cmp_data(wr_cmp_data),
        .wr_cmp_dmask(wr_cmp_dmask), .wr_ack(wr_ack)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic do_write(input logic [3:0] a, input logic v, input logic [2:0] d,
                            input logic [31:0] c, input logic [31:0] m);
        bit got = 0;
        wr_req = 1'b1; wr_addr = a; wr_valid = v; wr_data = d;
        wr_cmp_data = c; wr_cmp_dmask = m;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc();
            if (wr_ack) got = 1;
        end
        wr_req = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL write_timeout: wr_ack not seen for addr %0d", a);
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic clr);
        bit got = 0;
        rd_req = 1'b1; rd_addr = a; rd_clr_count = clr;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc();
            if (rd_ack) got = 1;
        end
        rd_req = 1'b0; rd_clr_count = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL read_timeout: rd_ack not seen for addr %0d", a);
        end
    endtask

    // Single lookup issued in cycle t; early_ack is the t+2 ack, others are t+3 outputs.
    task automatic do_lookup(input logic [31:0] key, input logic [31:0] dm,
                             output logic early_ack, output logic ack, output logic hit,
                             output logic multi, output logic [3:0] addr, output logic [2:0] data);
        lookup_req = 1'b1; lookup_cmp_data = key; lookup_cmp_dmask = dm;
        cyc();
        lookup_req = 1'b0;
        cyc();
        early_ack = lookup_ack;
        cyc();
        ack = lookup_ack; hit = lookup_hit; multi = lookup_multi;
        addr = lookup_addr; data = lookup_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lookup_req = 0; lookup_cmp_data = 0; lookup_cmp_dmask = 0;
        rd_req = 0; rd_addr = 0; rd_clr_count = 0;
        wr_req = 0; wr_addr = 0; wr_valid = 0; wr_data = 0; wr_cmp_data = 0; wr_cmp_dmask = 0;
        repeat (3) cyc();
        n_checks++;
        if (ready !== 1'b0 || lookup_ack !== 1'b0 || lookup_hit !== 1'b0 ||
            lookup_multi !== 1'b0 || lookup_addr !== 4'd0 || lookup_data !== DEF_D) begin
            n_errors++;
            $display("FAIL reset_lookup_outs: rdy=%0b ack=%0b hit=%0b multi=%0b addr=%0d data=%0d want 0 0 0 0 0 %0d",
                     ready, lookup_ack, lookup_hit, lookup_multi, lookup_addr, lookup_data, DEF_D);
        end
        n_checks++;
        if (rd_ack !== 1'b0 || wr_ack !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 3'd0 ||
            rd_cmp_data !== 32'd0 || rd_cmp_dmask !== 32'd0 || rd_hit_count !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_reg_outs: rd_ack=%0b wr_ack=%0b rd_valid=%0b rd_data=%0d cnt=%0d want all 0",
                     rd_ack, wr_ack, rd_valid, rd_data, rd_hit_count);
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (ready !== (k >= 16)) begin
                n_errors++;
                $display("FAIL sweep_ready: cycle %0d got %0b want %0b", k, ready, (k >= 16));
            end
            n_checks++;
            if (lookup_ack !== 1'b0) begin
                n_errors++;
                $display("FAIL sweep_no_ack: cycle %0d got lookup_ack=%0b want 0", k, lookup_ack);
            end
            lookup_req = (k == 5);
            lookup_cmp_dmask = 32'hFFFF_FFFF;
            cyc();
        end
        lookup_req = 1'b0; lookup_cmp_dmask = 32'd0;
        do_read(4'd3, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== RST_D || rd_hit_count !== 3'd0 ||
            rd_cmp_data !== 32'd0 || rd_cmp_dmask !== 32'd0) begin
            n_errors++;
            $display("FAIL init_entry3: valid=%0b data=%0d cnt=%0d cmp=%h mask=%h want 0 %0d 0 0 0",
                     rd_valid, rd_data, rd_hit_count, rd_cmp_data, rd_cmp_dmask, RST_D);
        end
    endtask

    task automatic test_basic_lookup();
        logic ea, a, h, m;
        logic [3:0] ad;
        logic [2:0] d;
        do_write(4'd2, 1'b1, 3'd5, 32'h0A00_0000, 32'h00FF_FFFF);
        do_lookup(32'h0A12_3456, 32'd0, ea, a, h, m, ad, d);
        n_checks++;
        if (ea !== 1'b0 || a !== 1'b1 || h !== 1'b1 || m !== 1'b0 || ad !== 4'd2 || d !== 3'd5) begin
            n_errors++;
            $display("FAIL basic_hit: early=%0b ack=%0b hit=%0b multi=%0b addr=%0d data=%0d want 0 1 1 0 2 5",
                     ea, a, h, m, ad, d);
        end
        do_lookup(32'h0B00_0000, 32'd0, ea, a, h, m, ad, d);
        n_checks++;
        if (a !== 1'b1 || h !== 1'b0 || m !== 1'b0 || ad !== 4'd0 || d !== DEF_D) begin
            n_errors++;
            $display("FAIL basic_miss: ack=%0b hit=%0b multi=%0b addr=%0d data=%0d want 1 0 0 0 %0d",
                     a, h, m, ad, d, DEF_D);
        end
        do_lookup(32'h0B12_3456, 32'h0100_0000, ea, a, h, m, ad, d);
        n_checks++;
        if (a !== 1'b1 || h !== 1'b1 || ad !== 4'd2 || d !== 3'd5) begin
            n_errors++;
            $display("FAIL lookup_dmask: ack=%0b hit=%0b addr=%0d data=%0d want 1 1 2 5", a, h, ad, d);
        end
    endtask

    task automatic test_multi_match();
        logic ea, a, h, m;
        logic [3:0] ad;
        logic [2:0] d;
        do_write(4'd1, 1'b1, 3'd3, 32'h1234_5678, 32'h0000_0000);
        do_write(4'd6, 1'b1, 3'd4, 32'h1234_0000, 32'h0000_FFFF);
        do_lookup(32'h1234_5678, 32'd0, ea, a, h, m, ad, d);
        n_checks++;
        if (a !== 1'b1 || h !== 1'b1 || m !== 1'b1 || ad !== 4'd1 || d !== 3'd3) begin
            n_errors++;
            $display("FAIL multi_prio: ack=%0b hit=%0b multi=%0b addr=%0d data=%0d want 1 1 1 1 3",
                     a, h, m, ad, d);
        end
        do_write(4'd1, 1'b0, 3'd3, 32'h1234_5678, 32'h0000_0000);
        do_lookup(32'h1234_5678, 32'd0, ea, a, h, m, ad, d);
        n_checks++;
        if (a !== 1'b1 || h !== 1'b1 || m !== 1'b0 || ad !== 4'd6 || d !== 3'd4) begin
            n_errors++;
            $display("FAIL multi_invalidate: ack=%0b hit=%0b multi=%0b addr=%0d data=%0d want 1 1 0 6 4",
                     a, h, m, ad, d);
        end
    endtask

    task automatic test_back_to_back();
        do_write(4'd4, 1'b1, 3'd7, 32'hCAFE_0000, 32'h0000_FFFF);
        lookup_cmp_dmask = 32'd0;
        for (int c = 0; c < 15; c++) begin
            n_checks++;
            if (lookup_ack !== (c >= 3 && c <= 12)) begin
                n_errors++;
                $display("FAIL b2b_ack: rel cycle %0d got %0b want %0b", c, lookup_ack, (c >= 3 && c <= 12));
            end
            if (c >= 3 && c <= 12) begin
                n_checks++;
                if (lookup_hit !== 1'b1 || lookup_addr !== 4'd4 || lookup_data !== 3'd7) begin
                    n_errors++;
                    $display("FAIL b2b_result: rel cycle %0d hit=%0b addr=%0d data=%0d want 1 4 7",
                             c, lookup_hit, lookup_addr, lookup_data);
                end
            end
            lookup_req = (c < 10);
            lookup_cmp_data = 32'hCAFE_0000 + 32'(c);
            cyc();
        end
        lookup_req = 1'b0;
        do_read(4'd4, 1'b0);
        n_checks++;
        if (rd_hit_count !== 3'd7 || rd_valid !== 1'b1 || rd_data !== 3'd7) begin
            n_errors++;
            $display("FAIL count_saturate: cnt=%0d valid=%0b data=%0d want 7 1 7", rd_hit_count, rd_valid, rd_data);
        end
        do_read(4'd4, 1'b1);
        n_checks++;
        if (rd_hit_count !== 3'd7) begin
            n_errors++;
            $display("FAIL clr_read_value: cnt=%0d want 7", rd_hit_count);
        end
        do_read(4'd4, 1'b0);
        n_checks++;
        if (rd_hit_count !== 3'd0) begin
            n_errors++;
            $display("FAIL count_cleared: cnt=%0d want 0", rd_hit_count);
        end
        // Clear lands on the same edge as an increment for entry 4.
        lookup_req = 1'b1; lookup_cmp_data = 32'hCAFE_1111;
        cyc();
        lookup_req = 1'b0;
        cyc();
        rd_req = 1'b1; rd_addr = 4'd4; rd_clr_count = 1'b1;
        cyc();
        rd_req = 1'b0; rd_clr_count = 1'b0;
        n_checks++;
        if (rd_ack !== 1'b1 || rd_hit_count !== 3'd0 || lookup_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_inc_read: rd_ack=%0b cnt=%0d lookup_ack=%0b want 1 0 1", rd_ack, rd_hit_count, lookup_ack);
        end
        do_read(4'd4, 1'b0);
        n_checks++;
        if (rd_hit_count !== 3'd1) begin
            n_errors++;
            $display("FAIL clr_inc_count: cnt=%0d want 1", rd_hit_count);
        end
    endtask

    task automatic test_arbitration();
        logic ea, a, h, m;
        logic [3:0] ad;
        logic [2:0] d;
        lookup_req = 1'b1; lookup_cmp_data = 32'd0; lookup_cmp_dmask = 32'd0;
        wr_req = 1'b1; wr_addr = 4'd9; wr_valid = 1'b1; wr_data = 3'd2;
        wr_cmp_data = 32'h55AA_55AA; wr_cmp_dmask = 32'd0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (wr_ack !== 1'b0) begin
                n_errors++;
                $display("FAIL wr_blocked: cycle %0d got wr_ack=%0b want 0", i + 1, wr_ack);
            end
            lookup_req = (i < 3);
        end
        cyc();
        n_checks++;
        if (wr_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_after_lookup: got wr_ack=%0b want 1", wr_ack);
        end
        wr_req = 1'b0;
        repeat (4) cyc();
        wr_req = 1'b1; wr_addr = 4'd10; wr_valid = 1'b1; wr_data = 3'd1;
        wr_cmp_data = 32'h0000_0077; wr_cmp_dmask = 32'd0;
        rd_req = 1'b1; rd_addr = 4'd9; rd_clr_count = 1'b0;
        cyc();
        n_checks++;
        if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL arb_write_first: wr_ack=%0b rd_ack=%0b want 1 0", wr_ack, rd_ack);
        end
        wr_req = 1'b0;
        cyc();
        n_checks++;
        if (rd_ack !== 1'b1 || wr_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL arb_read_second: rd_ack=%0b wr_ack=%0b want 1 0", rd_ack, wr_ack);
        end
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 3'd2 || rd_cmp_data !== 32'h55AA_55AA || rd_cmp_dmask !== 32'd0) begin
            n_errors++;
            $display("FAIL arb_read_data: valid=%0b data=%0d cmp=%h mask=%h want 1 2 55aa55aa 0",
                     rd_valid, rd_data, rd_cmp_data, rd_cmp_dmask);
        end
        cyc();
        do_lookup(32'h0000_0077, 32'd0, ea, a, h, m, ad, d);
        n_checks++;
        if (a !== 1'b1 || h !== 1'b1 || ad !== 4'd10 || d !== 3'd1) begin
            n_errors++;
            $display("FAIL arb_new_entry: ack=%0b hit=%0b addr=%0d data=%0d want 1 1 10 1", a, h, ad, d);
        end
    endtask

    task automatic test_reset_midstream();
        lookup_cmp_dmask = 32'd0;
        lookup_req = 1'b1; lookup_cmp_data = 32'hCAFE_0001;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        lookup_req = 1'b0;
        n_checks++;
        if (lookup_ack !== 1'b0 || ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_state: lookup_ack=%0b ready=%0b want 0 0", lookup_ack, ready);
        end
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (lookup_ack !== 1'b0 || ready !== (k >= 16)) begin
                n_errors++;
                $display("FAIL midreset_sweep: cycle %0d ack=%0b ready=%0b want 0 %0b",
                         k, lookup_ack, ready, (k >= 16));
            end
            cyc();
        end
        for (int e = 0; e < 16; e++) begin
            do_read(4'(e), 1'b0);
            n_checks++;
            if (rd_valid !== 1'b0 || rd_data !== RST_D || rd_cmp_data !== 32'd0 ||
                rd_cmp_dmask !== 32'd0 || rd_hit_count !== 3'd0) begin
                n_errors++;
                $display("FAIL midreset_entry: e=%0d valid=%0b data=%0d cmp=%h mask=%h cnt=%0d want 0 %0d 0 0 0",
                         e, rd_valid, rd_data, rd_cmp_data, rd_cmp_dmask, rd_hit_count, RST_D);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_lookup();
        test_multi_match();
        test_back_to_back();
        test_arbitration();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
